// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector line-buffer path: pixel/address widths,
// the frame reader state encoding and the default image geometry.
package edge_pkg;

    localparam int PIX_W              = 32;
    localparam int LB_ADDR_W          = 7;
    localparam int DEF_WORDS_PER_LINE = 40;
    localparam int DEF_FRAME_LINES    = 240;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/frame_reader_skid.sv
// One-entry skid buffer that parks a returning memory word while the shift path is stalled.
module frame_reader_skid
    import edge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] din,
    output logic             valid,
    output logic [PIX_W-1:0] dout
);

    logic             valid_q, valid_d;
    logic [PIX_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload carries no reset; it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/frame_reader.sv
// Reads one frame from a synchronous frame memory in raster order and streams it into the
// shift data path, tracking line-buffer address, column and window validity.
module frame_reader
    import edge_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int FRAME_LINES    = DEF_FRAME_LINES,
    parameter int MEM_AW         = 16,
    parameter int ADDR_MAX       = 75
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    output logic                 mem_rd_en,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic [PIX_W-1:0]     mem_rd_data,
    output logic                 write_en,
    output logic [LB_ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]     data_out,
    output logic                 window_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = MEM_AW + 1;
    localparam int COL_W = $clog2(WORDS_PER_LINE + 1);

    localparam logic [CNT_W-1:0]     TOTAL     = CNT_W'(WORDS_PER_LINE * FRAME_LINES);
    localparam logic [CNT_W-1:0]     PRIMED    = CNT_W'(2 * WORDS_PER_LINE + 2);
    localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [LB_ADDR_W-1:0] ADDR_LAST = LB_ADDR_W'(ADDR_MAX);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d, wr_cnt_inc;
    logic [LB_ADDR_W-1:0]   addr_q, addr_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   win_q, win_d;

    logic                   issue;
    logic                   push_out;
    logic                   skid_push;
    logic                   skid_pop;
    logic                   skid_valid;
    logic [PIX_W-1:0]       skid_data;

    // A read is only issued when its returning word is guaranteed a place to go next cycle.
    always_comb begin
        issue      = (state_q == STREAM) && (rd_cnt_q < TOTAL) && !stall && !skid_valid;
        push_out   = !stall && (skid_valid || rd_vld_q);
        skid_push  = rd_vld_q && stall;
        skid_pop   = skid_valid && !stall;
        wr_cnt_inc = wr_cnt_q + CNT_W'(1);
    end

    frame_reader_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push),
        .pop   (skid_pop),
        .din   (mem_rd_data),
        .valid (skid_valid),
        .dout  (skid_data)
    );

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        addr_d     = addr_q;
        col_d      = col_q;
        mem_addr_d = mem_addr_q;
        rd_vld_d   = issue;
        win_d      = 1'b0;

        if (issue) begin
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            mem_addr_d = rd_cnt_q[MEM_AW-1:0];
        end

        if (push_out) begin
            wr_cnt_d = wr_cnt_inc;
            addr_d   = (addr_q == ADDR_LAST) ? '0 : addr_q + LB_ADDR_W'(1);
            col_d    = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            // Column 0 would pair this word with the tail of the previous line.
            win_d    = (wr_cnt_inc >= PRIMED) && (col_q != '0);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    addr_d   = '0;
                    col_d    = '0;
                end
            end
            STREAM: begin
                if (push_out && (wr_cnt_inc == TOTAL)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            mem_addr_q <= '0;
            rd_vld_q   <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            mem_addr_q <= mem_addr_d;
            rd_vld_q   <= rd_vld_d;
            win_q      <= win_d;
        end
    end

    // The skid entry is always older than any word returning this cycle, so it drains first.
    always_comb begin
        mem_rd_en    = issue;
        mem_addr     = issue ? rd_cnt_q[MEM_AW-1:0] : mem_addr_q;
        write_en     = push_out;
        addr         = addr_q;
        data_out     = push_out ? (skid_valid ? skid_data : mem_rd_data) : '0;
        window_valid = win_q;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
    end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader on a 4x3-word frame with memory[i] = i + 1.
module tb_frame_reader;

    localparam int WPL  = 4;
    localparam int FL   = 3;
    localparam int AW   = 16;
    localparam int AMAX = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic        write_en;
    logic [6:0]  addr;
    logic [31:0] data_out;
    logic        window_valid;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] exp_addr [12] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5};

    frame_reader #(
        .WORDS_PER_LINE (WPL),
        .FRAME_LINES    (FL),
        .MEM_AW         (AW),
        .ADDR_MAX       (AMAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .write_en     (write_en),
        .addr         (addr),
        .data_out     (data_out),
        .window_valid (window_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 32'(mem_addr) + 32'd1;
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_rd_en got %0b want 0", mem_rd_en); end
        vectors++; if (mem_addr !== 16'd0) begin miscompares++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
        vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL reset_write_en got %0b want 0", write_en); end
        vectors++; if (addr !== 7'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", addr); end
        vectors++; if (data_out !== 32'd0) begin miscompares++; $display("FAIL reset_data_out got %0d want 0", data_out); end
        vectors++; if (window_valid !== 1'b0) begin miscompares++; $display("FAIL reset_window got %0b want 0", window_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_basic_frame;
        for (int c = 0; c <= 16; c++) begin
            logic e_rd, e_we, e_win, e_done, e_busy;
            start = (c == 0);
            stall = 1'b0;
            e_rd   = (c >= 1 && c <= 12);
            e_we   = (c >= 2 && c <= 13);
            e_win  = (c >= 12 && c <= 14);
            e_done = (c == 14);
            e_busy = (c >= 1 && c <= 14);
            @(negedge clk);
            vectors++; if (mem_rd_en !== e_rd) begin miscompares++; $display("FAIL basic_rd_en c=%0d got %0b want %0b", c, mem_rd_en, e_rd); end
            if (e_rd) begin
                vectors++; if (mem_addr !== 16'(c - 1)) begin miscompares++; $display("FAIL basic_mem_addr c=%0d got %0d want %0d", c, mem_addr, c - 1); end
            end
            vectors++; if (write_en !== e_we) begin miscompares++; $display("FAIL basic_write_en c=%0d got %0b want %0b", c, write_en, e_we); end
            if (e_we) begin
                vectors++; if (data_out !== 32'(c - 1)) begin miscompares++; $display("FAIL basic_data c=%0d got %0d want %0d", c, data_out, c - 1); end
                vectors++; if (addr !== exp_addr[c - 2]) begin miscompares++; $display("FAIL basic_addr c=%0d got %0d want %0d", c, addr, exp_addr[c - 2]); end
            end
            vectors++; if (window_valid !== e_win) begin miscompares++; $display("FAIL basic_window c=%0d got %0b want %0b", c, window_valid, e_win); end
            vectors++; if (done !== e_done) begin miscompares++; $display("FAIL basic_done c=%0d got %0b want %0b", c, done, e_done); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL basic_busy c=%0d got %0b want %0b", c, busy, e_busy); end
            next_cycle();
        end
    endtask

    task automatic test_back_pressure;
        int n = 0;
        for (int c = 0; c <= 20; c++) begin
            logic e_rd, e_we, e_done, e_busy;
            int   e_maddr;
            start = (c == 0);
            stall = (c >= 4 && c <= 6);
            e_rd    = (c >= 1 && c <= 3) || (c >= 8 && c <= 16);
            e_maddr = (c <= 3) ? c - 1 : c - 5;
            e_we    = (c == 2) || (c == 3) || (c == 7) || (c >= 9 && c <= 17);
            e_done  = (c == 18);
            e_busy  = (c >= 1 && c <= 18);
            @(negedge clk);
            vectors++; if (mem_rd_en !== e_rd) begin miscompares++; $display("FAIL stall_rd_en c=%0d got %0b want %0b", c, mem_rd_en, e_rd); end
            if (e_rd) begin
                vectors++; if (mem_addr !== 16'(e_maddr)) begin miscompares++; $display("FAIL stall_mem_addr c=%0d got %0d want %0d", c, mem_addr, e_maddr); end
            end
            if (c >= 4 && c <= 7) begin
                vectors++; if (mem_addr !== 16'd2) begin miscompares++; $display("FAIL stall_mem_addr_hold c=%0d got %0d want 2", c, mem_addr); end
            end
            vectors++; if (write_en !== e_we) begin miscompares++; $display("FAIL stall_write_en c=%0d got %0b want %0b", c, write_en, e_we); end
            if (e_we && n < 12) begin
                vectors++; if (data_out !== 32'(n + 1)) begin miscompares++; $display("FAIL stall_data c=%0d got %0d want %0d", c, data_out, n + 1); end
                vectors++; if (addr !== exp_addr[n]) begin miscompares++; $display("FAIL stall_addr c=%0d got %0d want %0d", c, addr, exp_addr[n]); end
                n++;
            end
            vectors++; if (done !== e_done) begin miscompares++; $display("FAIL stall_done c=%0d got %0b want %0b", c, done, e_done); end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL stall_busy c=%0d got %0b want %0b", c, busy, e_busy); end
            next_cycle();
        end
        stall = 1'b0;
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        for (int c = 0; c <= 18; c++) begin
            logic e_we, e_busy;
            start = (c == 0) || (c == 5);
            stall = 1'b0;
            e_we   = (c >= 2 && c <= 13);
            e_busy = (c >= 1 && c <= 14);
            @(negedge clk);
            if (c == 5) begin
                vectors++; if (mem_addr !== 16'd4) begin miscompares++; $display("FAIL restart_mem_addr got %0d want 4", mem_addr); end
            end
            vectors++; if (write_en !== e_we) begin miscompares++; $display("FAIL restart_write_en c=%0d got %0b want %0b", c, write_en, e_we); end
            if (e_we) begin
                vectors++; if (data_out !== 32'(c - 1)) begin miscompares++; $display("FAIL restart_data c=%0d got %0d want %0d", c, data_out, c - 1); end
                vectors++; if (addr !== exp_addr[c - 2]) begin miscompares++; $display("FAIL restart_addr c=%0d got %0d want %0d", c, addr, exp_addr[c - 2]); end
            end
            vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL restart_busy c=%0d got %0b want %0b", c, busy, e_busy); end
            if (done === 1'b1) dones++;
            next_cycle();
        end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL restart_done_count got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid_frame;
        int n = 0;
        int dones = 0;
        int first_we = -1;
        for (int c = 0; c <= 7; c++) begin
            start = (c == 0);
            rst   = (c == 7);
            @(negedge clk);
            if (c >= 2) begin
                vectors++; if (write_en !== 1'b1 || data_out !== 32'(c - 1)) begin miscompares++; $display("FAIL midrst_pre_data c=%0d got we=%0b data=%0d want we=1 data=%0d", c, write_en, data_out, c - 1); end
            end
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL midrst_mem_rd_en got %0b want 0", mem_rd_en); end
        vectors++; if (mem_addr !== 16'd0) begin miscompares++; $display("FAIL midrst_mem_addr got %0d want 0", mem_addr); end
        vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL midrst_write_en got %0b want 0", write_en); end
        vectors++; if (addr !== 7'd0) begin miscompares++; $display("FAIL midrst_addr got %0d want 0", addr); end
        vectors++; if (data_out !== 32'd0) begin miscompares++; $display("FAIL midrst_data_out got %0d want 0", data_out); end
        vectors++; if (window_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_window got %0b want 0", window_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %0b want 0", done); end
        next_cycle();
        for (int k = 0; k <= 30; k++) begin
            start = (k == 0);
            @(negedge clk);
            if (write_en === 1'b1) begin
                if (first_we < 0) first_we = k;
                vectors++;
                if (n >= 12) begin
                    miscompares++; $display("FAIL midrst_extra_write k=%0d got word %0d want none", k, data_out);
                end else if (data_out !== 32'(n + 1) || addr !== exp_addr[n]) begin
                    miscompares++; $display("FAIL midrst_stream k=%0d got data=%0d addr=%0d want data=%0d addr=%0d", k, data_out, addr, n + 1, exp_addr[n]);
                end
                n++;
            end
            if (done === 1'b1) dones++;
            next_cycle();
        end
        vectors++; if (n != 12) begin miscompares++; $display("FAIL midrst_word_count got %0d want 12", n); end
        vectors++; if (first_we != 2) begin miscompares++; $display("FAIL midrst_latency got %0d want 2", first_we); end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL midrst_done_count got %0d want 1", dones); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_final_busy got %0b want 0", busy); end
    endtask

    task automatic test_reset_priority;
        rst = 1'b1;
        start = 1'b1;
        next_cycle();
        rst = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL prio_busy c=%0d got %0b want 0", c, busy); end
            vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL prio_rd_en c=%0d got %0b want 0", c, mem_rd_en); end
            vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL prio_write_en c=%0d got %0b want 0", c, write_en); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_start_ignored();
        test_reset_mid_frame();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Producer end of the edge-detector line-buffer path.
- On a start pulse, reads one frame of 32-bit pixel words from a synchronous frame memory in raster order.
- Streams those words into the shift data path's input (write_en, addr, data_in). Replaces the stub frame feeder currently driving that path.
- Tracks line priming and column position, and flags when the 3x2 window on w0..w5 holds a valid, non-line-straddling neighbourhood.

Parameters:
- WORDS_PER_LINE, 40, 32-bit words per image line (shift_8 plus shift_32 depth).
- FRAME_LINES, 240, lines per frame.
- MEM_AW, 16, frame-memory address width; must satisfy WORDS_PER_LINE*FRAME_LINES <= 2**MEM_AW.
- ADDR_MAX, 75, last value of the 7-bit line-buffer address before wrap to 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to read a frame; ignored unless idle.
- stall  in  1  downstream back-pressure; while high, no word is pushed into the shift path.
- mem_rd_en  out  1  frame-memory read strobe.
- mem_addr  out  MEM_AW  frame-memory word address.
- mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en.
- write_en  out  1  push strobe to the shift data path.
- addr  out  7  line-buffer address to the shift_32 stages.
- data_out  out  32  pixel word to the shift data path data_in.
- window_valid  out  1  w0..w5 of the shift path form a valid window this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last word is written.

Behaviour:
- Reset: all outputs 0, state IDLE, read and write counters 0, skid register empty.
  - Reset mid-frame aborts immediately.
  - An in-flight memory word is discarded; no write_en in the cycle after reset.
- States:
  - IDLE: start -> STREAM, rd_cnt=0, wr_cnt=0, busy=1 from the next cycle.
  - STREAM: issue reads while rd_cnt < TOTAL (TOTAL = WORDS_PER_LINE*FRAME_LINES) and the pipe has space. When wr_cnt reaches TOTAL -> DONE.
  - DONE: done=1 and busy=1 for one cycle -> IDLE.
- Read issue: mem_rd_en=1 and mem_addr=rd_cnt when state=STREAM, rd_cnt<TOTAL, !stall and skid empty. rd_cnt increments on issue.
- Write path, latency 1 (read issued cycle N -> write_en cycle N+1 if no stall):
  - Returned word goes out as data_out with write_en=1 if stall is low that cycle; otherwise it is captured in a 1-entry skid register.
  - Skid contents are written, ahead of new reads, in the first cycle stall is low.
  - write_en=0 whenever stall=1. No word is dropped or duplicated.
- addr:
  - Increments by 1 after every write_en cycle; ADDR_MAX wraps to 0.
  - Resets to 0 on rst and on frame start.
  - addr presented with write_en is the pre-increment value.
- Column counter: col 0..WORDS_PER_LINE-1, advances on write_en, wraps to 0.
- window_valid is registered and is 1 in the cycle after a write_en when both hold:
  - wr_cnt (post-increment) >= 2*WORDS_PER_LINE+2 (the pipeline is primed);
  - the written word's col != 0 (the window does not straddle a line edge).
  - Otherwise 0, including every cycle without a preceding write.
- start while busy: ignored. start and rst in the same cycle: rst wins.
- stall in IDLE/DONE: no effect.
- mem_addr holds its last value when mem_rd_en=0.

Decomposition:
- Shared package edge_pkg:
  - PIX_W=32, LB_ADDR_W=7;
  - state enum (IDLE, STREAM, DONE);
  - default geometry constants WORDS_PER_LINE and FRAME_LINES, shared with shift_data_path.
- One natural sub-module: frame_reader_skid (1-entry skid buffer: valid/data, push/pop, stall-driven).
- Counters and FSM stay in frame_reader.

Test Plan:
- Bench parameters: WORDS_PER_LINE=4, FRAME_LINES=3, ADDR_MAX=5; memory[i]=i+1.
- Basic frame: start pulse, stall=0 -> write_en for 12 consecutive cycles starting 2 cycles after start; data_out 1..12; addr 0,1,2,3,4,5,0,1,...; done pulses once after word 12; busy then drops.
- Window flag: same run -> window_valid=1 only after words 10, 11, 12 (wr_cnt>=10, col!=0); it must stay 0 after word 9 (col 0).
- Back-pressure: stall high for 3 cycles, starting the cycle a read returns -> that word is held in the skid; write_en=0 for 3 cycles; data_out sequence still exactly 1..12 with no gaps or duplicates; no mem_rd_en while the skid is full.
- Start ignored: second start pulse during busy -> no restart; rd_cnt, wr_cnt and addr are unaffected; only one done.
- Reset mid-frame: rst after word 6 -> next cycle all outputs 0, state IDLE. A new start then gives data_out 1..12 with addr beginning at 0.
- Reset priority: rst and start in the same cycle -> remains IDLE, busy=0, no mem_rd_en.
